// File: rtl/reg_file_mp.sv
// Multi-read-port register file for the decode stage.
// Reset scrubs every entry to zero, one entry per cycle.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       ready
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic {
      SCRUB,
      READY
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      unique case (state_q)
         SCRUB: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_W-1:0];
            mem_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = READY;
            end
         end
         READY: begin
            mem_we = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
         end
         default: begin
            state_d = SCRUB;
         end
      endcase
      // Reset wins over both scrub and port writes.
      if (rst) begin
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SCRUB;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign ready = (state_q == READY);

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;

      assign ra = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         rv = mem_q[ra];
         if (state_q != READY) begin
            rv = '0;
         end else if (ZERO_REG != 0 && ra == '0) begin
            rv = '0;
         end else if (BYPASS != 0 && wr_en && ra == wr_addr) begin
            rv = wr_data;
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = rv;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: default, no-bypass,
// no-zero-reg and a narrow 4-port configuration.
module tb_reg_file_mp;

   logic        clk;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data0, rd_data1, rd_data2;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        ready0, ready1, ready2;

   logic        rst3;
   logic [11:0] rd_addr3;
   logic [63:0] rd_data3;
   logic        wr_en3;
   logic [2:0]  wr_addr3;
   logic [15:0] wr_data3;
   logic        ready3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e00, e01, e10, e11, e20, e21;
   } vec_t;
   vec_t vt[9];

   reg_file_mp u0 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready0)
   );

   reg_file_mp #(.BYPASS(0)) u1 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready1)
   );

   reg_file_mp #(.ZERO_REG(0)) u2 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready2)
   );

   reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) u3 (
      .clk(clk), .rst(rst3), .rd_addr(rd_addr3), .rd_data(rd_data3),
      .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .ready(ready3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push(input string name, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.exp  = exp;
      sbq.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] act);
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty actual=%h expected=none", act);
      end else begin
         e = sbq.pop_front();
         check(e.name, act, e.exp);
      end
   endtask

   // Counts posedges until ready; for u0 group, tries a write to entry 3
   // after that entry has already been scrubbed.
   task automatic scrub_wait(input int which, output int n);
      logic rdy;
      n = 0;
      while (n < 100) begin
         if (which == 0) begin
            wr_en   = (n == 5);
            wr_addr = 5'd3;
            wr_data = 32'hA5;
         end
         @(posedge clk);
         #1;
         n++;
         rdy = (which == 0) ? ready0 : ready3;
         if (rdy === 1'b1) break;
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic do_reset(input logic we);
      @(negedge clk);
      rst     = 1'b1;
      wr_en   = we;
      wr_addr = 5'd9;
      wr_data = 32'd77;
      rd_addr = {5'd31, 5'd31};
      @(negedge clk);
      rst   = 1'b0;
      wr_en = 1'b0;
      #2;
      check("rst_ready0", {31'd0, ready0}, 32'd0);
      check("rst_rd_u0", rd_data0[31:0], 32'd0);
      check("rst_rd_u2", rd_data2[31:0], 32'd0);
   endtask

   task automatic apply_vec(input int i);
      @(negedge clk);
      wr_en   = vt[i].we;
      wr_addr = vt[i].wa;
      wr_data = vt[i].wd;
      rd_addr = {vt[i].ra1, vt[i].ra0};
      push($sformatf("v%0d_u0_p0", i), vt[i].e00);
      push($sformatf("v%0d_u0_p1", i), vt[i].e01);
      push($sformatf("v%0d_u1_p0", i), vt[i].e10);
      push($sformatf("v%0d_u1_p1", i), vt[i].e11);
      push($sformatf("v%0d_u2_p0", i), vt[i].e20);
      push($sformatf("v%0d_u2_p1", i), vt[i].e21);
      #2;
      pop_check(rd_data0[31:0]);
      pop_check(rd_data0[63:32]);
      pop_check(rd_data1[31:0]);
      pop_check(rd_data1[63:32]);
      pop_check(rd_data2[31:0]);
      pop_check(rd_data2[63:32]);
   endtask

   initial begin
      int n;
      logic [15:0] v3 [8];

      vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0,
                32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
      vt[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5,
                32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                32'hDEADBEEF, 32'hDEADBEEF};
      vt[2] = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7,
                32'h12345678, 32'h12345678, 32'h0, 32'h0,
                32'h12345678, 32'h12345678};
      vt[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7,
                32'h0, 32'h12345678, 32'h0, 32'h12345678,
                32'hFFFFFFFF, 32'h12345678};
      vt[4] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd5,
                32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF,
                32'hFFFFFFFF, 32'hDEADBEEF};
      vt[5] = '{1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd7,
                32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF, 32'h12345678,
                32'hCAFEF00D, 32'h12345678};
      vt[6] = '{1'b0, 5'd0, 32'h0, 5'd31, 5'd5,
                32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D,
                32'h0, 32'hCAFEF00D};
      vt[7] = '{1'b1, 5'd31, 32'h11112222, 5'd31, 5'd30,
                32'h11112222, 32'h0, 32'h0, 32'h0, 32'h11112222, 32'h0};
      vt[8] = '{1'b0, 5'd0, 32'h0, 5'd31, 5'd7,
                32'h11112222, 32'h12345678, 32'h11112222, 32'h12345678,
                32'h11112222, 32'h12345678};

      rst      = 1'b1;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr  = '0;
      rst3     = 1'b1;
      wr_en3   = 1'b0;
      wr_addr3 = '0;
      wr_data3 = '0;
      rd_addr3 = '0;

      // Initial scrub
      do_reset(1'b0);
      scrub_wait(0, n);
      check("scrub_len_first", n, 32);
      check("ready1_first", {31'd0, ready1}, 32'd1);
      check("ready2_first", {31'd0, ready2}, 32'd1);

      // Write/read, bypass, zero-reg vectors
      for (int i = 0; i < 9; i++) apply_vec(i);

      // Reset with a concurrent write, then reset again mid-scrub
      do_reset(1'b1);
      repeat (10) @(posedge clk);
      #1;
      check("mid_ready0", {31'd0, ready0}, 32'd0);
      do_reset(1'b0);
      scrub_wait(0, n);
      check("scrub_len_restart", n, 32);
      check("ready1_restart", {31'd0, ready1}, 32'd1);
      check("ready2_restart", {31'd0, ready2}, 32'd1);

      // Every entry scrubbed, including the dropped scrub-time write
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rd_addr = {5'(31 - i), 5'(i)};
         push($sformatf("zero_u0_%0d", i), 32'h0);
         push($sformatf("zero_u1_%0d", 31 - i), 32'h0);
         push($sformatf("zero_u2_%0d", i), 32'h0);
         #2;
         pop_check(rd_data0[31:0]);
         pop_check(rd_data1[63:32]);
         pop_check(rd_data2[31:0]);
      end

      // Narrow 4-port configuration
      @(negedge clk);
      rst3 = 1'b0;
      #2;
      check("u3_rst_ready", {31'd0, ready3}, 32'd0);
      check("u3_rst_rd", rd_data3[31:0], 32'd0);
      scrub_wait(3, n);
      check("u3_scrub_len", n, 8);

      for (int i = 0; i < 8; i++) begin
         v3[i] = 16'hA000 + 16'(i) * 16'h0111;
         @(negedge clk);
         wr_en3   = 1'b1;
         wr_addr3 = 3'(i);
         wr_data3 = v3[i];
      end
      @(negedge clk);
      wr_en3 = 1'b0;

      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            rd_addr3[k*3 +: 3] = 3'((j + k) % 8);
            push($sformatf("u3_r%0d_p%0d", j, k), {16'h0, v3[(j + k) % 8]});
         end
         #2;
         for (int k = 0; k < 4; k++) begin
            pop_check({16'h0, rd_data3[k*16 +: 16]});
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
